bidim_rr_arbiter: RTL

Round-robin arbitration stage that sits directly upstream of the bidimensional mux. It takes DEPTH valid/ready request channels packed on the same flattened bus layout the mux consumes (channel i at bits [i*WIDTH +: WIDTH]) and picks one winner per cycle. It registers the winning word and its index into a single-entry output stage with valid/ready backpressure. The registered index is exported as m_ctrl, so the mux can replay the selection against the same bus.

---
 rtl/bidim_rr_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/bidim_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bidim_rr_arbiter
// Brief    : Round-robin arbiter over a flattened request bus, feeding a
//            registered single-entry output stage with the winning index.
// Revision : 1.0
// ============================================================================
module bidim_rr_arbiter #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DEPTH-1:0]           req_valid,
    input  logic [WIDTH*DEPTH-1:0]     req_data,
    output logic [DEPTH-1:0]           req_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH)-1:0]   m_ctrl,
    input  logic                       out_ready
);

    localparam int SEL_WIDTH = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       data_q;
    logic [SEL_WIDTH-1:0]   sel_q;
    logic [SEL_WIDTH-1:0]   ptr_q;
    logic [SEL_WIDTH-1:0]   ptr_d;

    logic                   load_en;
    logic                   found;
    logic [SEL_WIDTH-1:0]   winner;
    logic [SEL_WIDTH:0]     idx;
    logic [WIDTH-1:0]       win_data;

    assign load_en = (state_q == ST_EMPTY) | out_ready;

    // Rotating scan starting at ptr_q; wrap is modulo DEPTH so a
    // non-power-of-two DEPTH never produces an out-of-range index.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = {1'b0, ptr_q} + (SEL_WIDTH+1)'(k);
            if (idx >= (SEL_WIDTH+1)'(DEPTH)) begin
                idx = idx - (SEL_WIDTH+1)'(DEPTH);
            end
            if (!found && req_valid[idx[SEL_WIDTH-1:0]]) begin
                found  = 1'b1;
                winner = idx[SEL_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (winner == SEL_WIDTH'(i)) begin
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_d = (winner == SEL_WIDTH'(DEPTH-1)) ? '0 : winner + 1'b1;

    always_comb begin
        req_ready = '0;
        if (found && load_en && !rst) begin
            req_ready = DEPTH'(1) << winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else if (load_en) begin
            if (found) begin
                state_q <= ST_FULL;
                data_q  <= win_data;
                sel_q   <= winner;
                ptr_q   <= ptr_d;
            end else begin
                state_q <= ST_EMPTY;
            end
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign m_ctrl    = sel_q;

endmodule
`default_nettype wire
